// File: rtl/fib_controller.sv
// fib_controller: control FSM for a stack-based recursive Fibonacci datapath.
// The datapath (n, f, res, ret registers, ALU and call stack) is external; this
// block sequences it through descent, base case, and unwind/combine phases.
// Optional build macro: FIB_CTRL_OVF_CHECK_EN enables the call-depth overflow
// abort (err) at MAX_DEPTH stacked frames.
module fib_controller #(
  parameter int unsigned MAX_DEPTH = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] n_req,
  input  logic       lt,
  input  logic [7:0] f,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       push,
  output logic       pop,
  output logic       addsub,
  output logic       ress,
  output logic       resld,
  output logic       resrst,
  output logic       retld,
  output logic       retrst,
  output logic       ns,
  output logic       nld,
  output logic       nrst,
  output logic       fs,
  output logic       fld,
  output logic       frst,
  output logic [1:0] rets,
  output logic [1:0] addrs,
  output logic [1:0] addls,
  output logic [1:0] ss
);

  typedef enum logic [3:0] {
    IDLE, INIT, LOAD, TEST, BASE, PUSHF, PUSHN, PUSHR,
    DEC, RET, POPR, POPN, POPF, COMB, DONE
  } state_t;

  state_t     state, state_d;
  logic [7:0] load_cnt, load_cnt_d;
  logic [7:0] depth, depth_d;
  logic       ovf;
  logic       unused_f;

  assign unused_f = ^f[7:1];

`ifdef FIB_CTRL_OVF_CHECK_EN
  logic err_q;

  assign ovf = !lt && (depth == 8'(MAX_DEPTH));
  assign err = err_q;

  // Overflow flag: cleared by an accepted start, set when TEST aborts on depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (state == IDLE && start) begin
      err_q <= 1'b0;
    end else if (state == TEST && ovf) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_cap;

  assign ovf        = 1'b0;
  assign err        = 1'b0;
  assign unused_cap = (depth == 8'(MAX_DEPTH));
`endif

  // State, load counter and frame depth registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      load_cnt <= '0;
      depth    <= '0;
    end else begin
      state    <= state_d;
      load_cnt <= load_cnt_d;
      depth    <= depth_d;
    end
  end

  // Next-state, counter updates and datapath control decode.
  always_comb begin
    state_d    = state;
    load_cnt_d = load_cnt;
    depth_d    = depth;
    busy       = 1'b1;
    done       = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    addsub     = 1'b0;
    ress       = 1'b0;
    resld      = 1'b0;
    resrst     = 1'b0;
    retld      = 1'b0;
    retrst     = 1'b0;
    ns         = 1'b0;
    nld        = 1'b0;
    nrst       = 1'b0;
    fs         = 1'b0;
    fld        = 1'b0;
    frst       = 1'b0;
    rets       = 2'd0;
    addrs      = 2'd0;
    addls      = 2'd0;
    ss         = 2'd0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d    = INIT;
          load_cnt_d = n_req;
          depth_d    = '0;
        end
      end
      INIT: begin
        nrst    = 1'b1;
        frst    = 1'b1;
        resrst  = 1'b1;
        retrst  = 1'b1;
        state_d = LOAD;
      end
      // n is built up by repeated increments from zero.
      LOAD: begin
        if (load_cnt != '0) begin
          nld        = 1'b1;
          addls      = 2'd1;
          addrs      = 2'd2;
          load_cnt_d = load_cnt - 8'd1;
        end else begin
          state_d = TEST;
        end
      end
      TEST: begin
        if (ovf)     state_d = DONE;
        else if (lt) state_d = BASE;
        else         state_d = PUSHF;
      end
      BASE: begin
        retld   = 1'b1;
        state_d = RET;
      end
      PUSHF: begin
        push    = 1'b1;
        state_d = PUSHN;
      end
      PUSHN: begin
        push    = 1'b1;
        ss      = 2'd1;
        state_d = PUSHR;
      end
      PUSHR: begin
        push    = 1'b1;
        ss      = 2'd2;
        depth_d = depth + 8'd1;
        state_d = DEC;
      end
      // f[0] selects which recursive call is being made: n-1 first, then n-2.
      DEC: begin
        nld     = 1'b1;
        addls   = 2'd1;
        addsub  = 1'b1;
        addrs   = f[0] ? 2'd3 : 2'd2;
        frst    = 1'b1;
        state_d = TEST;
      end
      RET: begin
        state_d = (depth == '0) ? DONE : POPR;
      end
      POPR: begin
        pop     = 1'b1;
        ress    = 1'b1;
        resld   = 1'b1;
        state_d = POPN;
      end
      POPN: begin
        pop     = 1'b1;
        ns      = 1'b1;
        nld     = 1'b1;
        state_d = POPF;
      end
      POPF: begin
        pop     = 1'b1;
        fs      = 1'b1;
        fld     = 1'b1;
        if (depth != '0) depth_d = depth - 8'd1;
        state_d = COMB;
      end
      // After the first call, stash its result and re-enter for n-2;
      // after the second, sum both results and return.
      COMB: begin
        if (!f[0]) begin
          resld   = 1'b1;
          addrs   = 2'd1;
          fld     = 1'b1;
          state_d = PUSHF;
        end else begin
          retld   = 1'b1;
          rets    = 2'd1;
          addls   = 2'd2;
          addrs   = 2'd1;
          state_d = RET;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fib_controller.sv
// Testbench for fib_controller: behavioural datapath model plus a scoreboard
// checked on every done pulse.
module tb_fib_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] n_req = 8'd0;
  logic       lt;
  logic [7:0] f;
  logic       busy, done, err, push, pop, addsub;
  logic       ress, resld, resrst, retld, retrst, ns, nld, nrst, fs, fld, frst;
  logic [1:0] rets, addrs, addls, ss;

  fib_controller #(.MAX_DEPTH(10)) dut (
    .clk(clk), .rst(rst), .start(start), .n_req(n_req), .lt(lt), .f(f),
    .busy(busy), .done(done), .err(err), .push(push), .pop(pop), .addsub(addsub),
    .ress(ress), .resld(resld), .resrst(resrst), .retld(retld), .retrst(retrst),
    .ns(ns), .nld(nld), .nrst(nrst), .fs(fs), .fld(fld), .frst(frst),
    .rets(rets), .addrs(addrs), .addls(addls), .ss(ss)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Datapath model
  logic [7:0] dn = 8'd0, df = 8'd0, dres = 8'd0, dret = 8'd0;
  logic [7:0] stk[$];
  logic [7:0] top, al, ar, alu;
  assign lt = (dn < 8'd2);
  assign f  = df;

  logic c_push, c_pop, c_addsub, c_ress, c_resld, c_resrst, c_retld, c_retrst;
  logic c_ns, c_nld, c_nrst, c_fs, c_fld, c_frst;
  logic [1:0] c_rets, c_addrs, c_addls, c_ss;

  always @(posedge clk) begin
    top = (stk.size() > 0) ? stk[$] : 8'd0;
    al  = (c_addls == 2'd1) ? dn : (c_addls == 2'd2) ? dres : 8'd0;
    case (c_addrs)
      2'd1:    ar = dret;
      2'd2:    ar = 8'd1;
      2'd3:    ar = 8'd2;
      default: ar = 8'd0;
    endcase
    alu = c_addsub ? (al - ar) : (al + ar);
    if (c_push) stk.push_back((c_ss == 2'd0) ? df : (c_ss == 2'd1) ? dn : dres);
    if (c_pop && stk.size() > 0) void'(stk.pop_back());
    if (c_nrst) dn <= 8'd0;
    else if (c_nld) dn <= c_ns ? top : alu;
    if (c_frst) df <= 8'd0;
    else if (c_fld) df <= c_fs ? top : (df + 8'd1);
    if (c_resrst) dres <= 8'd0;
    else if (c_resld) dres <= c_ress ? top : alu;
    if (c_retrst) dret <= 8'd0;
    else if (c_retld) dret <= c_rets[0] ? alu : 8'd1;
  end

  // Scoreboard
  typedef struct {
    int n;
    int ret;
    int maxd;
    int lat;
    bit err;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int  done_cnt = 0;
  int  pushes = 0, pops = 0, maxd = 0, lat = 0;
  bit  prev_busy = 1'b0;

  always @(negedge clk) begin
    c_push = push; c_pop = pop; c_addsub = addsub; c_ress = ress; c_resld = resld;
    c_resrst = resrst; c_retld = retld; c_retrst = retrst; c_ns = ns; c_nld = nld;
    c_nrst = nrst; c_fs = fs; c_fld = fld; c_frst = frst; c_rets = rets;
    c_addrs = addrs; c_addls = addls; c_ss = ss;
    if (!rst) begin
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        pushes = 0; pops = 0; maxd = 0; lat = 0;
      end
      if (busy) lat++;
      if (push) pushes++;
      if (pop) pops++;
      if ((pushes - pops) / 3 > maxd) maxd = (pushes - pops) / 3;
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("err n=%0d", e.n), 32'(err), 32'(e.err));
          check($sformatf("maxdepth n=%0d", e.n), 32'(maxd), 32'(e.maxd));
          if (e.ret >= 0) check($sformatf("ret n=%0d", e.n), 32'(dret), 32'(e.ret));
          if (e.lat > 0) check($sformatf("latency n=%0d", e.n), 32'(lat), 32'(e.lat));
          if (!e.err) check($sformatf("push_pop_balance n=%0d", e.n), 32'(pushes), 32'(pops));
        end
      end
      prev_busy = busy;
    end
  end

  logic [24:0] all_out;
  assign all_out = {busy, done, err, push, pop, addsub, ress, resld, resrst, retld,
                    retrst, ns, nld, nrst, fs, fld, frst, rets, addrs, addls, ss};

  int exp_done = 0;

  task automatic pulse_start(input logic [7:0] n);
    @(negedge clk);
    n_req = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (done_cnt < exp_done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check({"done_timeout ", name}, 32'(done_cnt >= exp_done), 32'd1);
  endtask

  task automatic run_op(input int n, input int ret, input int md, input int lt_exp, input bit er);
    exp_t x;
    x.n = n; x.ret = ret; x.maxd = md; x.lat = lt_exp; x.err = er;
    sb.push_back(x);
    exp_done++;
    pulse_start(8'(n));
    wait_done($sformatf("n=%0d", n));
  endtask

  // Directed vectors: n, fib(n) with fib(0)=fib(1)=1, max frames, latency (0 = unchecked)
  int vec[5][4] = '{'{0, 1, 0, 6}, '{2, 2, 1, 0}, '{3, 3, 2, 0}, '{4, 5, 3, 0}, '{5, 8, 4, 0}};

  initial begin
    #1 rst = 1'b0;
    #2 check("reset_outputs", 32'(all_out), 32'd0);
    repeat (2) @(negedge clk);
    check("reset_outputs_held", 32'(all_out), 32'd0);
    rst = 1'b1;

    foreach (vec[i]) run_op(vec[i][0], vec[i][1], vec[i][2], vec[i][3], 1'b0);

    // Start during busy must be ignored
    sb.push_back('{n: 1, ret: 1, maxd: 0, lat: 7, err: 1'b0});
    exp_done++;
    pulse_start(8'd1);
    n_req = 8'd7;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done("busy_start");
    repeat (12) @(negedge clk);
    check("no_extra_done", 32'(done_cnt), 32'(exp_done));

    // Asynchronous reset while in DEC
    sb.push_back('{n: 6, ret: 13, maxd: 5, lat: 0, err: 1'b0});
    pulse_start(8'd6);
    begin
      int cyc = 0;
      while (!(nld && frst) && cyc < 500) begin
        @(negedge clk);
        cyc++;
      end
      check("reach_dec", 32'(nld && frst), 32'd1);
    end
    #1 rst = 1'b0;
    #1 check("async_reset_outputs", 32'(all_out), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_op(3, 3, 2, 0, 1'b0);

`ifdef FIB_CTRL_OVF_CHECK_EN
    run_op(20, -1, 10, 0, 1'b1);
    repeat (3) @(negedge clk);
    check("err_held_idle", 32'(err), 32'd1);
    run_op(2, 2, 1, 0, 1'b0);
`else
    run_op(12, 233, 11, 0, 1'b0);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
